// File: rtl/uart_serdes_core.sv
// -----------------------------------------------------------------------------
// uart_serdes_core
// Serial front end of the UART NIC. It contains one TX serializer and one RX
// deserializer that share a clock but operate independently. Frames are:
// start bit (0), WORD_SIZE data bits LSB first, optional even parity, and a
// stop bit (1). The line idles high.
//
// Build option: define UART_PARITY_EN to add one even-parity bit after the data
// bits. When it is defined, the port rx_perr_i is also present.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   rx         in   serial input, asynchronous to clk
//   data_read  out  last correctly received word, held until the next one
//   rx_avbl_i  out  one-cycle pulse: data_read newly valid
//   data_send  in   word to transmit
//   tx_send_i  in   one-cycle request to send data_send (ignored while busy)
//   tx_avbl_i  out  1 = transmitter idle and able to accept a request
//   rx_perr_i  out  (UART_PARITY_EN only) one-cycle parity-mismatch pulse
//   tx         out  registered serial output
// -----------------------------------------------------------------------------
module uart_serdes_core #(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [WORD_SIZE-1:0] data_read,
    output logic                 rx_avbl_i,
    input  logic [WORD_SIZE-1:0] data_send,
    input  logic                 tx_send_i,
    output logic                 tx_avbl_i,
`ifdef UART_PARITY_EN
    output logic                 rx_perr_i,
`endif
    output logic                 tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WORD_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // The RX start check fires one half bit in. That position is later
    // compensated by the full-bit spacing, so data samples land at bit centres.
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);

`ifdef UART_PARITY_EN
    // Even parity: XOR of all data bits, so that data plus parity has an even count of ones.
    function automatic logic even_parity(input logic [WORD_SIZE-1:0] d);
        return ^d;
    endfunction
`endif

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t              tx_state_r;
    logic [CW-1:0]          tx_cnt_r;
    logic [BW-1:0]          tx_bit_r;
    logic [WORD_SIZE-1:0]   tx_shift_r;
`ifdef UART_PARITY_EN
    logic                   tx_par_r;
    logic                   rx_perr_seen_r;
`endif

    rx_state_t              rx_state_r;
    logic [CW-1:0]          rx_cnt_r;
    logic [BW-1:0]          rx_bit_r;
    logic [WORD_SIZE-1:0]   rx_shift_r;
    logic                   rx_meta_r;
    logic                   rx_sync_r;

    // TX serializer: one bit every CLKS_PER_BIT cycles, with tx driven straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            tx_shift_r <= '0;
`ifdef UART_PARITY_EN
            tx_par_r   <= 1'b0;
`endif
            tx         <= 1'b1;
            tx_avbl_i  <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx        <= 1'b1;
                    tx_avbl_i <= 1'b1;
                    tx_cnt_r  <= '0;
                    tx_bit_r  <= '0;
                    if (tx_send_i) begin
                        tx_shift_r <= data_send;
`ifdef UART_PARITY_EN
                        tx_par_r   <= even_parity(data_send);
`endif
                        tx         <= 1'b0;
                        tx_avbl_i  <= 1'b0;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx         <= tx_shift_r[0];
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_bit_r == BIT_LAST) begin
                            tx_bit_r   <= '0;
`ifdef UART_PARITY_EN
                            tx         <= tx_par_r;
                            tx_state_r <= TX_PARITY;
`else
                            tx         <= 1'b1;
                            tx_state_r <= TX_STOP;
`endif
                        end else begin
                            tx_bit_r   <= tx_bit_r + BW'(1);
                            tx_shift_r <= {1'b0, tx_shift_r[WORD_SIZE-1:1]};
                            tx         <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx         <= 1'b1;
                        tx_state_r <= TX_STOP;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx         <= 1'b1;
                        tx_avbl_i  <= 1'b1;
                        tx_state_r <= TX_IDLE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_cnt_r   <= '0;
                    tx_bit_r   <= '0;
                    tx         <= 1'b1;
                    tx_avbl_i  <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer for rx. Its reset value is idle-high, so that reset is not seen as a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX deserializer. IDLE is only re-entered once the line has been seen high,
    // so a low level in IDLE always means a fresh falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r     <= RX_IDLE;
            rx_cnt_r       <= '0;
            rx_bit_r       <= '0;
            rx_shift_r     <= '0;
            data_read      <= '0;
            rx_avbl_i      <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_i      <= 1'b0;
            rx_perr_seen_r <= 1'b0;
`endif
        end else begin
            rx_avbl_i <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_i <= 1'b0;
`endif
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_bit_r <= '0;
`ifdef UART_PARITY_EN
                    rx_perr_seen_r <= 1'b0;
`endif
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == CNT_HALF) begin
                        rx_cnt_r   <= '0;
                        // If the line is high at the middle of the start bit, it was a glitch.
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[WORD_SIZE-1:1]};
                        if (rx_bit_r == BIT_LAST) begin
                            rx_bit_r   <= '0;
`ifdef UART_PARITY_EN
                            rx_state_r <= RX_PARITY;
`else
                            rx_state_r <= RX_STOP;
`endif
                        end else begin
                            rx_bit_r <= rx_bit_r + BW'(1);
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_STOP;
                        if (rx_sync_r != even_parity(rx_shift_r)) begin
                            rx_perr_i      <= 1'b1;
                            rx_perr_seen_r <= 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r <= '0;
                        if (rx_sync_r) begin
`ifdef UART_PARITY_EN
                            if (!rx_perr_seen_r) begin
                                data_read <= rx_shift_r;
                                rx_avbl_i <= 1'b1;
                            end
`else
                            data_read  <= rx_shift_r;
                            rx_avbl_i  <= 1'b1;
`endif
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_state_r <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    rx_cnt_r <= '0;
                    if (rx_sync_r) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= '0;
                    rx_bit_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_serdes_core.sv
// -----------------------------------------------------------------------------
// tb_uart_serdes_core
// Directed bench for uart_serdes_core at WORD_SIZE=8, CLKS_PER_BIT=16.
// When the tb drives rx itself, tx is not looped back to rx. Otherwise tx is
// fed straight back to rx, which exercises both directions at the same time.
// Outputs are sampled on the falling edge, and inputs are also changed there.
// -----------------------------------------------------------------------------
module tb_uart_serdes_core;

    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_read;
    logic       rx_avbl_i;
    logic [7:0] data_send;
    logic       tx_send_i;
    logic       tx_avbl_i;
    logic       tx;
`ifdef UART_PARITY_EN
    logic       rx_perr_i;
`endif

    logic loop_en;
    logic rx_drv;
    int   err_cnt;
    int   chk_cnt;
    int   pulse_cnt;
    int   pulse_exp;
    int   perr_cnt;

    assign rx = loop_en ? tx : rx_drv;

    uart_serdes_core #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_read (data_read),
        .rx_avbl_i (rx_avbl_i),
        .data_send (data_send),
        .tx_send_i (tx_send_i),
        .tx_avbl_i (tx_avbl_i),
`ifdef UART_PARITY_EN
        .rx_perr_i (rx_perr_i),
`endif
        .tx        (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count receive pulses (and parity-error pulses) as they are seen.
    always @(negedge clk) begin
        if (rx_avbl_i === 1'b1) pulse_cnt++;
`ifdef UART_PARITY_EN
        if (rx_perr_i === 1'b1) perr_cnt++;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word on tx, starting at a falling edge, and check every bit at its centre.
    // If busy is set, a second request (0x77) is issued mid-frame and must be ignored.
    task automatic tx_frame(input logic [7:0] d, input bit busy);
        logic [10:0] bits;
        int          w;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_PARITY_EN
        bits[9]   = ^d;
`endif
        tx_send_i = 1'b1;
        data_send = d;
        @(negedge clk);
        tx_send_i = 1'b0;
        check_eq("tx_start_edge", {31'd0, tx}, 32'd0);
        check_eq("tx_avbl_drop", {31'd0, tx_avbl_i}, 32'd0);
        for (int k = 0; k < NBITS; k++) begin
            w = (k == 0) ? 7 : 16;
            for (int c = 0; c < w; c++) begin
                @(negedge clk);
                if (busy && k == 4 && c == 0) begin
                    tx_send_i = 1'b1;
                    data_send = 8'h77;
                end else if (busy && k == 4 && c == 1) begin
                    tx_send_i = 1'b0;
                    data_send = d;
                end
            end
            check_eq($sformatf("tx_bit%0d", k), {31'd0, tx}, {31'd0, bits[k]});
            check_eq($sformatf("tx_busy%0d", k), {31'd0, tx_avbl_i}, 32'd0);
        end
        repeat (8) @(negedge clk);
        check_eq("tx_avbl_last_stop", {31'd0, tx_avbl_i}, 32'd0);
        @(negedge clk);
        check_eq("tx_avbl_rise", {31'd0, tx_avbl_i}, 32'd1);
    endtask

    // Drive a frame on rx directly. stop_bit=0 makes a framing error, and
    // par_flip corrupts the parity bit.
    task automatic rx_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = d[k];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`else
        if (par_flip) rx_drv = 1'b1;
`endif
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        pulse_cnt = 0;
        pulse_exp = 0;
        perr_cnt  = 0;
        rst       = 1'b0;
        loop_en   = 1'b1;
        rx_drv    = 1'b1;
        tx_send_i = 1'b0;
        data_send = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_tx_avbl", {31'd0, tx_avbl_i}, 32'd1);
        check_eq("rst_rx_avbl", {31'd0, rx_avbl_i}, 32'd0);
        check_eq("rst_data_read", {24'd0, data_read}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Loopback of 0xA5
        tx_frame(8'hA5, 1'b0);
        pulse_exp++;
        check_eq("lb_a5_pulses", pulse_cnt, pulse_exp);
        check_eq("lb_a5_data", {24'd0, data_read}, 32'h0000_00A5);

        // Back-to-back: 0x00, then 0xFF on the first idle cycle
        tx_frame(8'h00, 1'b0);
        pulse_exp++;
        check_eq("b2b_00_pulses", pulse_cnt, pulse_exp);
        check_eq("b2b_00_data", {24'd0, data_read}, 32'h0000_0000);
        tx_frame(8'hFF, 1'b0);
        pulse_exp++;
        check_eq("b2b_ff_pulses", pulse_cnt, pulse_exp);
        check_eq("b2b_ff_data", {24'd0, data_read}, 32'h0000_00FF);

        // Busy ignore: 0x77 requested mid-frame of 0x11
        repeat (5) @(negedge clk);
        tx_frame(8'h11, 1'b1);
        pulse_exp++;
        repeat (NBITS * CPB + 20) @(negedge clk);
        check_eq("busy_tx_idle", {31'd0, tx}, 32'd1);
        check_eq("busy_avbl", {31'd0, tx_avbl_i}, 32'd1);
        check_eq("busy_pulses", pulse_cnt, pulse_exp);
        check_eq("busy_data", {24'd0, data_read}, 32'h0000_0011);

        // Glitch: a 4-cycle low pulse must not start a frame
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (5) @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_no_pulse", pulse_cnt, pulse_exp);
        rx_frame(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        pulse_exp++;
        check_eq("glitch_3c_pulses", pulse_cnt, pulse_exp);
        check_eq("glitch_3c_data", {24'd0, data_read}, 32'h0000_003C);

        // Framing error: 0x5A with a low stop bit, line held low afterwards
        rx_frame(8'h5A, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("ferr_no_pulse", pulse_cnt, pulse_exp);
        check_eq("ferr_data_kept", {24'd0, data_read}, 32'h0000_003C);
        rx_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        pulse_exp++;
        check_eq("ferr_81_pulses", pulse_cnt, pulse_exp);
        check_eq("ferr_81_data", {24'd0, data_read}, 32'h0000_0081);

`ifdef UART_PARITY_EN
        // Corrupted parity: an error pulse and no data pulse
        repeat (10) @(negedge clk);
        rx_frame(8'h42, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("perr_pulses", perr_cnt, 1);
        check_eq("perr_no_avbl", pulse_cnt, pulse_exp);
        check_eq("perr_data_kept", {24'd0, data_read}, 32'h0000_0081);
`endif

        // Reset in the middle of a TX frame (cycle 50)
        repeat (10) @(negedge clk);
        tx_send_i = 1'b1;
        data_send = 8'h99;
        @(negedge clk);
        tx_send_i = 1'b0;
        repeat (49) @(negedge clk);
        check_eq("mid_busy", {31'd0, tx_avbl_i}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
        check_eq("mid_rst_avbl", {31'd0, tx_avbl_i}, 32'd1);
        check_eq("mid_rst_data", {24'd0, data_read}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (CPB * 2) @(negedge clk);
        check_eq("post_rst_tx", {31'd0, tx}, 32'd1);
        check_eq("post_rst_avbl", {31'd0, tx_avbl_i}, 32'd1);

        // Recovery after reset: loopback of 0xC3
        loop_en = 1'b1;
        tx_frame(8'hC3, 1'b0);
        pulse_exp++;
        check_eq("rec_c3_pulses", pulse_cnt, pulse_exp);
        check_eq("rec_c3_data", {24'd0, data_read}, 32'h0000_00C3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
